// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Width of one serial step; the datapath processes one nibble per cycle.
  localparam int NIBBLE_W = 4;

  // Control states of the adder sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_add4_slice.sv
`default_nettype none
// ============================================================================
// Module      : add4_slice
// Description : Combinational 4-bit ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module add4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  // Carry chain: w_c[0] is the slice carry-in, w_c[NIBBLE_W] the carry-out.
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = cin_i;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = w_c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Adds two WIDTH-bit unsigned operands plus carry-in, one nibble
//               per clock, through a single 4-bit slice. Valid/ready on both
//               sides; all outputs come straight from registers.
//               Optional macro NIBBLE_SERIAL_ADDER_OVF_EN adds the out_ovf
//               two's-complement overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_q;
  logic [IDX_W-1:0]     idx_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                 ovf_q;
`endif

  // Slice results are the next-state values of the current nibble and carry.
  logic [NIBBLE_W-1:0]  nib_d;
  logic                 carry_d;
  logic                 last_nib;

  assign last_nib = (idx_q == IDX_W'(N - 1));

  add4_slice u_slice (
    .a_i    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b_i    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .cin_i  (carry_q),
    .sum_o  (nib_d),
    .cout_o (carry_d)
  );

  // Sequencer and datapath: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            sum_q      <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q      <= 1'b0;
`endif
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) begin
            // The final slice produces the sign bit of the sum.
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (nib_d[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  // After the last nibble the carry register holds the full-width carry-out.
  assign out_cout  = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand set present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have ports in_a and in_b, input, WIDTH bits: unsigned addends.
REQ-007 SHALL have port in_cin, input, 1 bit: carry-in.
REQ-008 SHALL have port out_valid, output, 1 bit: result present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-010 SHALL have port out_sum, output, WIDTH bits: in_a + in_b + in_cin modulo 2^WIDTH.
REQ-011 SHALL have port out_cout, output, 1 bit: carry-out of the full-width sum.
REQ-012 SHALL have port out_ovf, output, 1 bit: two's-complement overflow; present only per REQ-027.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/4 nibble steps.
REQ-014 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL, on in_valid&&in_ready, latch in_a, in_b, load carry register with in_cin, clear nibble index to 0, clear out_sum, enter RUN.
REQ-016 SHALL, each RUN cycle, add nibble[index] of both operands plus carry register through one 4-bit slice, write the 4-bit result into out_sum[4*index+3:4*index], load carry register with slice carry-out, increment index.
REQ-017 SHALL leave RUN for DONE on the cycle index==N-1 is processed; out_valid first high exactly N rising edges after the accept edge (WIDTH=4: 1 edge).
REQ-018 SHALL drive out_cout from carry register after the last nibble.
REQ-019 SHALL hold out_sum, out_cout, out_ovf and out_valid stable in DONE while out_ready=0, indefinitely.
REQ-020 SHALL, on out_valid&&out_ready, return to IDLE; result registers retain last value but are meaningful only with out_valid.
REQ-021 SHALL ignore in_valid and operand changes outside IDLE; no accept in the same cycle as the output handshake (min. spacing N+2 cycles per transaction).
REQ-022 SHALL be combinationally independent: no path from in_* or out_ready to any output.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, enter IDLE and clear out_sum, out_cout, out_ovf, carry register, index, latched operands to 0.
REQ-024 SHALL give in_ready=1, out_valid=0 from the edge rst is sampled high.
REQ-025 SHALL abandon any in-flight transaction on reset in RUN or DONE; no result is ever presented for it.
REQ-026 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-027 SHALL, with NIBBLE_SERIAL_ADDER_OVF_EN defined, provide out_ovf = (a[WIDTH-1]==b[WIDTH-1]) && (out_sum[WIDTH-1]!=a[WIDTH-1]), valid with out_valid; without it, out_ovf port and logic SHALL be absent.

Structure
REQ-028 SHALL place state enum and NIBBLE_W=4 constant in package nibble_serial_adder_pkg.
REQ-029 SHALL instantiate exactly one sub-module, add4_slice: combinational 4-bit a, 4-bit b, carry-in to 4-bit sum, carry-out, ripple-carry.
REQ-030 SHALL size the index register to clog2(N), minimum 1 bit.

Verification
REQ-031 SHALL cover: WIDTH=16, 0x00FF+0x0001, cin=0 -> out_sum=0x0100, out_cout=0, out_valid exactly 4 edges after accept.
REQ-032 SHALL cover: 0xFFFF+0x0000, cin=1 -> out_sum=0x0000, out_cout=1 (carry across all nibbles).
REQ-033 SHALL cover: result 0x1234+0x1111=0x2345 with out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout; handshake on release -> in_ready=1 next cycle.
REQ-034 SHALL cover: rst pulsed after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, out_sum=0, no stale result later.
REQ-035 SHALL cover (macro defined): 0x7FFF+0x0001 -> 0x8000, out_ovf=1; 0x8000+0x8000 -> 0x0000, out_cout=1, out_ovf=1; 0x0001+0x0001 -> out_ovf=0.
REQ-036 SHALL cover: WIDTH=4, 0xF+0x1, cin=1 -> out_sum=0x1, out_cout=1, out_valid 1 edge after accept.
